// File: rtl/axi4_lite_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge: one outstanding transfer, round-robin write/read arbitration.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module axi4_lite_apb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [2:0]              awprot,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [2:0]              arprot,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [2:0]              pprot,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pready,
   input  logic                    pslverr
);

   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WRESP, S_RRESP} state_t;

   state_t                r_state, w_next;
   logic                  r_prio_wr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_prot;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]     r_strb;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;

   logic w_idle, w_wr_pend, w_rd_pend, w_grant_wr, w_grant_rd, w_timeout;

   assign w_idle     = (r_state == S_IDLE);
   assign w_wr_pend  = awvalid & wvalid;
   assign w_rd_pend  = arvalid;
   assign w_grant_wr = w_idle & w_wr_pend & (~w_rd_pend | r_prio_wr);
   assign w_grant_rd = w_idle & w_rd_pend & (~w_wr_pend | ~r_prio_wr);

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo_cnt;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                          r_tmo_cnt <= '0;
      else if (r_state == S_SETUP)           r_tmo_cnt <= '0;
      else if (r_state == S_ACCESS && !pready) r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end

   // Fires on the stalled cycle that brings the count up to the limit
   assign w_timeout = (r_state == S_ACCESS) & ~pready &
                      (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   // No limit in this build; ACCESS waits for pready indefinitely
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_grant_wr | w_grant_rd) w_next = S_SETUP;
         S_SETUP:  w_next = S_ACCESS;
         S_ACCESS: if (pready | w_timeout) w_next = r_write ? S_WRESP : S_RRESP;
         S_WRESP:  if (bready) w_next = S_IDLE;
         S_RRESP:  if (rready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      awready = w_grant_wr;
      wready  = w_grant_wr;
      arready = w_grant_rd;
      psel    = (r_state == S_SETUP) | (r_state == S_ACCESS);
      penable = (r_state == S_ACCESS);
      bvalid  = (r_state == S_WRESP);
      rvalid  = (r_state == S_RRESP);
      bresp   = (r_state == S_WRESP) ? {r_err, 1'b0} : 2'b00;
      rresp   = (r_state == S_RRESP) ? {r_err, 1'b0} : 2'b00;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_prio_wr <= 1'b1;
         r_addr    <= '0;
         r_prot    <= '0;
         r_wdata   <= '0;
         r_strb    <= '0;
         r_write   <= 1'b0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_grant_wr | w_grant_rd) begin
            r_addr  <= w_grant_wr ? awaddr : araddr;
            r_prot  <= w_grant_wr ? awprot : arprot;
            r_wdata <= w_grant_wr ? wdata  : '0;
            r_strb  <= w_grant_wr ? wstrb  : '0;
            r_write <= w_grant_wr;
            // Priority only rotates when both sides actually competed
            if (w_wr_pend & w_rd_pend) r_prio_wr <= ~r_prio_wr;
         end
         if (r_state == S_ACCESS && pready) begin
            r_err <= pslverr;
            if (!r_write) r_rdata <= prdata;
         end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_write) r_rdata <= '0;
         end
      end
   end

   assign paddr  = r_addr;
   assign pprot  = r_prot;
   assign pwrite = r_write;
   assign pwdata = r_wdata;
   assign pstrb  = r_strb;
   assign rdata  = r_rdata;

endmodule

// File: tb/tb_axi4_lite_apb_bridge.sv
// Directed + randomized bench for axi4_lite_apb_bridge; reference model tracks arbitration and expected APB/AXI values.
module tb_axi4_lite_apb_bridge;

   logic        aclk = 1'b0, aresetn = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0, prdata = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        pready = 1'b0, pslverr = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, psel, penable, pwrite;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, paddr, pwdata;
   logic [2:0]  pprot;
   logic [3:0]  pstrb;

   int n_chk = 0, n_err = 0;
   bit prio_wr = 1'b1;

   axi4_lite_apb_bridge dut (
      .aclk(aclk), .aresetn(aresetn),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk); #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {awready, wready, arready, bvalid, rvalid, psel, penable, pwrite}, 64'd0);
      chk({tag, "_paddr"}, paddr, 64'd0);
      chk({tag, "_apbdata"}, {pwdata, pstrb, pprot}, 64'd0);
      chk({tag, "_rdata"}, rdata, 64'd0);
      chk({tag, "_resp"}, {bresp, rresp}, 64'd0);
   endtask

   // One full transaction starting in IDLE at posedge+1; model decides the grant.
   task automatic xact(input bit wr_req, input bit rd_req,
                       input logic [31:0] aw, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [2:0] wp, input logic [31:0] ar, input logic [2:0] rp,
                       input int waits, input bit err, input logic [31:0] prd,
                       input int hold, input int aw_only);
      bit gw;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_strb;
      logic [2:0]  e_prot;
      if (wr_req && rd_req) begin gw = prio_wr; prio_wr = !prio_wr; end
      else gw = wr_req;
      e_addr = gw ? aw : ar;
      e_wd   = gw ? wd : 32'd0;
      e_strb = gw ? ws : 4'd0;
      e_prot = gw ? wp : rp;
      awaddr = aw; wdata = wd; wstrb = ws; awprot = wp; araddr = ar; arprot = rp;
      for (int k = 0; k < aw_only; k++) begin
         awvalid = 1'b1; wvalid = 1'b0; arvalid = 1'b0;
         @(negedge aclk);
         chk("aw_only_ready", {awready, wready, arready}, 64'd0);
         step();
      end
      awvalid = wr_req; wvalid = wr_req; arvalid = rd_req;
      @(negedge aclk);
      chk("accept_wr", {awready, wready}, {62'd0, gw, gw});
      chk("accept_rd", arready, rd_req && !gw);
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge aclk);
      chk("setup_ctl", {psel, penable, pwrite}, {61'd0, 1'b1, 1'b0, gw});
      chk("setup_addr", paddr, e_addr);
      step();
      for (int k = 0; k <= waits; k++) begin
         pready = (k == waits);
         pslverr = (k == waits) ? err : 1'b0;
         prdata = (k == waits) ? prd : $urandom;
         @(negedge aclk);
         chk("access_ctl", {psel, penable, bvalid, rvalid}, 64'b1100);
         chk("access_addr", paddr, e_addr);
         chk("access_data", {pwdata, pstrb, pprot, pwrite}, {e_wd, e_strb, e_prot, gw});
         step();
      end
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      for (int h = 0; h <= hold; h++) begin
         if (h < hold) begin awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; end
         else begin awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = gw; rready = !gw; end
         @(negedge aclk);
         chk("resp_apb_idle", {psel, penable, awready, wready, arready}, 64'd0);
         if (gw) begin
            chk("bvalid", {bvalid, rvalid}, 64'b10);
            chk("bresp", bresp, {62'd0, err, 1'b0});
         end else begin
            chk("rvalid", {bvalid, rvalid}, 64'b01);
            chk("rresp", rresp, {62'd0, err, 1'b0});
            chk("rdata", rdata, prd);
         end
         step();
      end
      bready = 1'b0; rready = 1'b0;
      @(negedge aclk);
      chk("resp_done", {bvalid, rvalid}, 64'd0);
      step();
   endtask

   initial begin
      int cnt;
      #12;
      chk_reset_outputs("reset");
      @(negedge aclk); aresetn = 1'b1;
      step();

      xact(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 32'h0, 3'd0, 0, 0, 32'h0, 0, 0);
      xact(0, 1, 32'h0, 32'h0, 4'h0, 3'd0, 32'h24, 3'd2, 3, 0, 32'h12345678, 0, 0);
      xact(1, 1, 32'h40, 32'hA5A5_0001, 4'h3, 3'd1, 32'h44, 3'd5, 0, 0, 32'h0BAD_F00D, 0, 0);
      xact(1, 1, 32'h48, 32'hA5A5_0002, 4'hC, 3'd6, 32'h4C, 3'd4, 1, 0, 32'hCAFE_0002, 0, 0);
      xact(1, 0, 32'h80, 32'h1111_2222, 4'h5, 3'd3, 32'h0, 3'd0, 0, 1, 32'h0, 5, 0);
      xact(1, 0, 32'h90, 32'h3333_4444, 4'hA, 3'd7, 32'h0, 3'd0, 1, 0, 32'h0, 0, 4);

      for (int i = 0; i < 12; i++) begin
         int kind;
         kind = $urandom_range(0, 2);
         xact(kind != 1, kind != 0, $urandom, $urandom, 4'($urandom), 3'($urandom),
              $urandom, 3'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom, $urandom_range(0, 2), 0);
      end

      // Force priority to read side, then reset mid-ACCESS and confirm it returns to write
      if (!prio_wr) xact(1, 1, 32'hA0, 32'h5, 4'h1, 3'd0, 32'hA4, 3'd0, 0, 0, 32'h6, 0, 0);
      xact(1, 1, 32'hB0, 32'h7, 4'h1, 3'd0, 32'hB4, 3'd0, 0, 0, 32'h8, 0, 0);
      awaddr = 32'hC0; wdata = 32'hFEED_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      step();
      pready = 1'b0;
      #2 aresetn = 1'b0;
      #1 chk_reset_outputs("midreset");
      @(negedge aclk); aresetn = 1'b1;
      prio_wr = 1'b1;
      step();
      xact(1, 1, 32'hD0, 32'h9, 4'h2, 3'd0, 32'hD4, 3'd0, 0, 0, 32'hA, 0, 0);

`ifdef APB_TIMEOUT_EN
      araddr = 32'hE0; arprot = 3'd0; arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      step();
      pready = 1'b0;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge aclk);
         if (!penable) break;
         cnt++;
         step();
      end
      chk("tmo_cycles", cnt, 64'd16);
      chk("tmo_ctl", {psel, penable, rvalid}, 64'b001);
      chk("tmo_rresp", rresp, 64'd2);
      chk("tmo_rdata", rdata, 64'd0);
      rready = 1'b1;
      step();
      rready = 1'b0;
      @(negedge aclk);
      chk("tmo_done", rvalid, 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
